// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-master arbiter in front of a single-port data memory. m0 is the CPU
//   and m1 is the debug/loader port. m0 wins contended cycles until m1 has
//   waited STARVE_MAX consecutive cycles; then m1 is forced through once.
//   Grants are combinational. Reads return one cycle after acceptance.
//   Misaligned accesses are accepted, but no memory command is issued, and
//   they raise a one-cycle err on the next cycle.
//
// Parameters
//   STARVE_MAX : contended cycles m1 may lose before it is forced a grant
//   AW         : byte address width
//
// Ports
//   clk, reset                  : clock, asynchronous active-low reset
//   mX_req/we/adr/wdata         : request side of master X (X = 0, 1)
//   mX_gnt                      : same-cycle grant to master X
//   mX_rvalid/rdata/err         : response side of master X
//   mem_en/MemWrite/DataAdr/WriteData : memory command
//   mem_rdata                   : memory read data, one cycle after a read
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int unsigned STARVE_MAX = 3,
  parameter int unsigned AW         = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [31:0]   m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic          m0_err,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [31:0]   m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic          m1_err,
  output logic [31:0]   m1_rdata,
  output logic          mem_en,
  output logic          MemWrite,
  output logic [AW-1:0] DataAdr,
  output logic [31:0]   WriteData,
  input  logic [31:0]   mem_rdata
);

  // The starvation counter is wide enough to hold STARVE_MAX, and is never
  // narrower than one bit.
  localparam int unsigned SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  logic [SW-1:0] starve_cnt;
  logic          starved;
  logic          rd_pend;
  owner_e        owner;
  logic          m0_err_q;
  logic          m1_err_q;

  logic          any_gnt;
  logic          sel_we;
  logic [AW-1:0] sel_adr;
  logic [31:0]   sel_wdata;
  logic          misaligned;

  assign starved = (starve_cnt == SW'(STARVE_MAX));

  // Grant logic. Holding reset low blocks every grant, even when a
  // request is present.
  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a signal unassigned. Without the default, a latch would be
  // inferred.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (reset) begin
      if (m0_req && m1_req) begin
        m1_gnt = starved;
        m0_gnt = !starved;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  assign any_gnt   = m0_gnt | m1_gnt;
  assign sel_we    = m1_gnt ? m1_we    : m0_we;
  assign sel_adr   = m1_gnt ? m1_adr   : m0_adr;
  assign sel_wdata = m1_gnt ? m1_wdata : m0_wdata;

  // A granted access that is not word aligned is still accepted by the
  // master. It does not reach the memory; it is reported through err.
  assign misaligned = any_gnt && (sel_adr[1:0] != 2'b00);

  assign mem_en    = any_gnt && !misaligned;
  assign MemWrite  = mem_en && sel_we;
  assign DataAdr   = any_gnt ? sel_adr   : '0;
  assign WriteData = any_gnt ? sel_wdata : '0;

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples the values that were present before the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pend    <= 1'b0;
      owner      <= OWN_M0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      starve_cnt <= '0;
    end else begin
      rd_pend  <= mem_en && !sel_we;
      owner    <= m1_gnt ? OWN_M1 : OWN_M0;
      m0_err_q <= m0_gnt && misaligned;
      m1_err_q <= m1_gnt && misaligned;
      // The counter measures the run of cycles in which m1 asked and lost.
      // Any cycle that breaks the run restarts the count.
      if (m1_req && !m1_gnt) begin
        if (!starved) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  // Reset clears the registers, so a read accepted just before reset can
  // never surface once reset is released.
  assign m0_rvalid = rd_pend && (owner == OWN_M0);
  assign m1_rvalid = rd_pend && (owner == OWN_M1);
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;
  assign m0_err    = m0_err_q;
  assign m1_err    = m1_err_q;

endmodule
